banco_registradores_param: RTL and testbench
============================================

BANCO_REGISTRADORES_PARAM -- requirements
Module: banco_registradores_param

Interface
REQ-001 The block SHALL have one clock and one reset; reset is asynchronous and active-low.
REQ-002 Parameter LARGURA, default 32: data width of each register, in bits.
REQ-003 Parameter BITS_END, default 5: address width; register count NREG = 2**BITS_END.
REQ-004 Parameter BYPASS, default 1: 1 enables write-to-read forwarding, 0 disables it.
REQ-005 Port clk, input, 1: clock; all state updates on its rising edge.
REQ-006 Port rst_n, input, 1: asynchronous active-low reset.
REQ-007 Port rl1, input, BITS_END: read address, port 1.
REQ-008 Port rl2, input, BITS_END: read address, port 2.
REQ-009 Port resc, input, BITS_END: write address.
REQ-010 Port dado, input, LARGURA: write data.
REQ-011 Port h_esc, input, 1: write enable (writeback).
REQ-012 Port rres, input, BITS_END: reservation address (destination of an issued instruction).
REQ-013 Port h_res, input, 1: reservation enable.
REQ-014 Port d1, output, LARGURA: read data, port 1.
REQ-015 Port d2, output, LARGURA: read data, port 2.
REQ-016 Port ocupado1, output, 1: register at rl1 has a pending write.
REQ-017 Port ocupado2, output, 1: register at rl2 has a pending write.
REQ-018 Port pendentes, output, BITS_END+1: registered count of set busy bits.
REQ-019 Port erro, output, 1: sticky flag, set when a reservation hits an already-busy register.

Function
REQ-020 Storage SHALL be NREG registers of LARGURA bits plus one busy bit per register.
REQ-021 Register 0 SHALL always read 0; its busy bit SHALL always be 0; writes and reservations to address 0 SHALL be ignored.
REQ-022 Write: at a rising clk with h_esc=1 and resc!=0, x[resc] SHALL take dado and busy[resc] SHALL clear.
REQ-023 Reads SHALL be combinational: d1 = x[rl1], d2 = x[rl2].
REQ-024 With BYPASS=1, h_esc=1 and resc==rlN!=0, dN SHALL equal dado in the same cycle.
REQ-025 With BYPASS=0, dN SHALL show the new value only from the cycle after the write.
REQ-026 Reservation: at a rising clk with h_res=1 and rres!=0, busy[rres] SHALL set.
REQ-027 Write and reservation to the same address in the same cycle: data SHALL be written and busy SHALL end at 1 (reservation wins).
REQ-028 ocupadoN SHALL equal busy[rlN], masked to 0 when BYPASS=1 and a write to rlN is active in that cycle.
REQ-029 Reservation with h_res=1, rres!=0 and busy[rres] already 1 (not cleared by a simultaneous write): erro SHALL set at that edge and hold until reset; busy stays 1.
REQ-030 pendentes SHALL equal the number of set busy bits after each edge:
- +1 on a new reservation;
- -1 on a write clearing a busy bit;
- net 0 when both occur on the same address, or on distinct addresses in the same cycle.
REQ-031 pendentes SHALL never exceed NREG-1 or go below 0.
REQ-032 A write to a non-busy register SHALL still update data and SHALL NOT change pendentes.

Reset
REQ-033 rst_n=0 SHALL immediately, independent of clk, clear all registers, all busy bits, pendentes and erro to 0.
REQ-034 During reset, d1=d2=0 and ocupado1=ocupado2=0.
REQ-035 Writes and reservations presented while rst_n=0 SHALL be discarded.
REQ-036 Deassertion SHALL take effect at the next rising clk.
REQ-037 Reset asserted mid-operation SHALL clear pending reservations, without restoring them.

Verification
REQ-038 Write x5=0xDEADBEEF, then rl1=5 -> d1=0xDEADBEEF; write x0=0x1234, rl2=0 -> d2=0.
REQ-039 BYPASS=1: h_esc=1, resc=7, dado=0xA5A5A5A5, rl1=7 in the same cycle -> d1=0xA5A5A5A5 and ocupado1=0 before the edge; BYPASS=0 -> d1 holds the old value until after the edge.
REQ-040 Reserve x3 -> ocupado1=1 (rl1=3), pendentes=1; write x3=9 -> ocupado1=0, pendentes=0, d1=9.
REQ-041 Reserve x4 twice without a write -> erro=1 after the second edge, pendentes=1; simultaneous write+reserve on x4 -> erro unchanged, busy[4]=1.
REQ-042 Reserve x1, x2, x3 (pendentes=3), write x8=0x55, then pulse rst_n low between edges -> d1, d2 read 0 for x8 and all registers, pendentes=0, erro=0, ocupado=0 immediately.

Source files
------------

// File: rtl/banco_registradores_param.sv
// banco_registradores_param: register file with busy-bit scoreboard, optional write forwarding and pending count
module banco_registradores_param #(
   parameter int LARGURA  = 32,
   parameter int BITS_END = 5,
   parameter int BYPASS   = 1
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [BITS_END-1:0] rl1,
   input  logic [BITS_END-1:0] rl2,
   input  logic [BITS_END-1:0] resc,
   input  logic [LARGURA-1:0]  dado,
   input  logic                h_esc,
   input  logic [BITS_END-1:0] rres,
   input  logic                h_res,
   output logic [LARGURA-1:0]  d1,
   output logic [LARGURA-1:0]  d2,
   output logic                ocupado1,
   output logic                ocupado2,
   output logic [BITS_END:0]   pendentes,
   output logic                erro
);
   localparam int NREG = 2 ** BITS_END;
   localparam int P    = BITS_END + 1;

   logic [LARGURA-1:0] x [NREG];
   logic [NREG-1:0]    busy, busy_nxt;
   logic               wr_en, res_en, wr_clr, res_new, err_hit, byp1, byp2;

   assign wr_en   = h_esc && (resc != '0);
   assign res_en  = h_res && (rres != '0);
   assign wr_clr  = wr_en && busy[resc];
   // a reservation only adds a busy bit if the target is free, or is freed by a write in this same cycle
   assign res_new = res_en && (!busy[rres] || (wr_clr && (resc == rres)));
   assign err_hit = res_en && busy[rres] && !(wr_en && (resc == rres));
   assign byp1    = (BYPASS != 0) && wr_en && (resc == rl1);
   assign byp2    = (BYPASS != 0) && wr_en && (resc == rl2);

   // next busy vector: write clears, reservation sets afterwards so it wins on the same address
   always_comb begin
      busy_nxt = busy;
      if (wr_en) busy_nxt[resc] = 1'b0;
      if (res_en) busy_nxt[rres] = 1'b1;
      busy_nxt[0] = 1'b0;
   end

   // combinational reads with forwarding; everything forced to zero while reset is held
   always_comb begin
      d1       = !rst_n || (rl1 == '0) ? '0 : byp1 ? dado : x[rl1];
      d2       = !rst_n || (rl2 == '0) ? '0 : byp2 ? dado : x[rl2];
      ocupado1 = rst_n && busy[rl1] && !byp1;
      ocupado2 = rst_n && busy[rl2] && !byp2;
   end

   // state: register data, busy bits, incremental pending count and sticky error
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NREG; i++) x[i] <= '0;
         busy      <= '0;
         pendentes <= '0;
         erro      <= 1'b0;
      end else begin
         if (wr_en) x[resc] <= dado;
         busy      <= busy_nxt;
         pendentes <= pendentes + P'(res_new) - P'(wr_clr);
         erro      <= erro | err_hit;
      end
   end
endmodule

// File: tb/tb_banco_registradores_param.sv
// tb_banco_registradores_param: table, directed and random checks of both bypass variants against a reference model
module tb_banco_registradores_param;
   localparam int W = 32;
   localparam int A = 5;
   localparam int N = 32;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic [A-1:0] rl1, rl2, resc, rres;
   logic [W-1:0] dado;
   logic         h_esc, h_res;
   logic [W-1:0] d1, d2, d1_0, d2_0;
   logic         oc1, oc2, oc1_0, oc2_0, erro, erro_0;
   logic [A:0]   pend, pend_0;

   int checks = 0;
   int errors = 0;

   logic [W-1:0] mx [N];
   logic [N-1:0] mb;
   logic         merr;

   typedef struct {
      logic         he;
      logic [A-1:0] rc;
      logic [W-1:0] dd;
      logic         hr;
      logic [A-1:0] rr, a1, a2;
      logic [W-1:0] ed1, ed2;
      logic         eo1;
      logic [A:0]   ep;
      logic         ee;
   } vec_t;
   vec_t tbl [11];

   banco_registradores_param #(.LARGURA(W), .BITS_END(A), .BYPASS(1)) dut (
      .clk(clk), .rst_n(rst_n), .rl1(rl1), .rl2(rl2), .resc(resc), .dado(dado), .h_esc(h_esc),
      .rres(rres), .h_res(h_res), .d1(d1), .d2(d2), .ocupado1(oc1), .ocupado2(oc2),
      .pendentes(pend), .erro(erro));

   banco_registradores_param #(.LARGURA(W), .BITS_END(A), .BYPASS(0)) dut0 (
      .clk(clk), .rst_n(rst_n), .rl1(rl1), .rl2(rl2), .resc(resc), .dado(dado), .h_esc(h_esc),
      .rres(rres), .h_res(h_res), .d1(d1_0), .d2(d2_0), .ocupado1(oc1_0), .ocupado2(oc2_0),
      .pendentes(pend_0), .erro(erro_0));

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   function automatic void mreset();
      for (int i = 0; i < N; i++) mx[i] = '0;
      mb   = '0;
      merr = 1'b0;
   endfunction

   function automatic logic [W-1:0] md(input logic [A-1:0] rl, input bit byp);
      if (!rst_n || rl == 0) return '0;
      if (byp && h_esc && resc == rl) return dado;
      return mx[rl];
   endfunction

   function automatic logic mo(input logic [A-1:0] rl, input bit byp);
      if (!rst_n || rl == 0) return 1'b0;
      if (byp && h_esc && resc == rl) return 1'b0;
      return mb[rl];
   endfunction

   function automatic void mstep();
      if (h_res && rres != 0 && mb[rres] && !(h_esc && resc == rres)) merr = 1'b1;
      if (h_esc && resc != 0) begin
         mx[resc] = dado;
         mb[resc] = 1'b0;
      end
      if (h_res && rres != 0) mb[rres] = 1'b1;
   endfunction

   task automatic chk_model();
      chk("d1_byp", d1, md(rl1, 1));
      chk("d2_byp", d2, md(rl2, 1));
      chk("oc1_byp", W'(oc1), W'(mo(rl1, 1)));
      chk("oc2_byp", W'(oc2), W'(mo(rl2, 1)));
      chk("pend_byp", W'(pend), W'($countones(mb)));
      chk("erro_byp", W'(erro), W'(merr));
      chk("d1_nobyp", d1_0, md(rl1, 0));
      chk("d2_nobyp", d2_0, md(rl2, 0));
      chk("oc1_nobyp", W'(oc1_0), W'(mo(rl1, 0)));
      chk("oc2_nobyp", W'(oc2_0), W'(mo(rl2, 0)));
      chk("pend_nobyp", W'(pend_0), W'($countones(mb)));
      chk("erro_nobyp", W'(erro_0), W'(merr));
   endtask

   task automatic drive(input logic he, input logic [A-1:0] rc, input logic [W-1:0] dd,
                        input logic hr, input logic [A-1:0] rr, input logic [A-1:0] a1, input logic [A-1:0] a2);
      h_esc = he; resc = rc; dado = dd; h_res = hr; rres = rr; rl1 = a1; rl2 = a2;
   endtask

   task automatic edge_step();
      @(posedge clk);
      if (rst_n) mstep();
      @(negedge clk);
   endtask

   initial begin
      drive(1'b1, 5'd2, 32'h1111_2222, 1'b1, 5'd2, 5'd2, 5'd2);
      mreset();
      #1;
      chk("rst_d1_masked", d1, '0);
      chk("rst_oc1", W'(oc1), '0);
      chk("rst_pend", W'(pend), '0);
      chk("rst_erro", W'(erro), '0);
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      drive(1'b0, 5'd0, '0, 1'b0, 5'd0, 5'd2, 5'd0);
      #1;
      chk("rst_discard_d1", d1, '0);
      chk("rst_discard_oc1", W'(oc1), '0);
      chk_model();
      edge_step();

      tbl[0]  = '{1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 5'd5, 5'd0, 32'hDEADBEEF, 32'h0, 1'b0, 6'd0, 1'b0};
      tbl[1]  = '{1'b1, 5'd0, 32'h00001234, 1'b0, 5'd0, 5'd5, 5'd0, 32'hDEADBEEF, 32'h0, 1'b0, 6'd0, 1'b0};
      tbl[2]  = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd3, 5'd3, 5'd0, 32'h0,        32'h0, 1'b0, 6'd0, 1'b0};
      tbl[3]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 5'd3, 5'd0, 32'h0,        32'h0, 1'b1, 6'd1, 1'b0};
      tbl[4]  = '{1'b1, 5'd3, 32'h9,        1'b0, 5'd0, 5'd3, 5'd0, 32'h9,        32'h0, 1'b0, 6'd1, 1'b0};
      tbl[5]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 5'd3, 5'd5, 32'h9, 32'hDEADBEEF, 1'b0, 6'd0, 1'b0};
      tbl[6]  = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd4, 5'd4, 5'd0, 32'h0,        32'h0, 1'b0, 6'd0, 1'b0};
      tbl[7]  = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd4, 5'd4, 5'd0, 32'h0,        32'h0, 1'b1, 6'd1, 1'b0};
      tbl[8]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 5'd4, 5'd0, 32'h0,        32'h0, 1'b1, 6'd1, 1'b1};
      tbl[9]  = '{1'b1, 5'd4, 32'h77,       1'b1, 5'd4, 5'd4, 5'd0, 32'h77,       32'h0, 1'b0, 6'd1, 1'b1};
      tbl[10] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 5'd4, 5'd0, 32'h77,       32'h0, 1'b1, 6'd1, 1'b1};
      for (int i = 0; i < 11; i++) begin
         drive(tbl[i].he, tbl[i].rc, tbl[i].dd, tbl[i].hr, tbl[i].rr, tbl[i].a1, tbl[i].a2);
         #1;
         chk($sformatf("tbl%0d_d1", i), d1, tbl[i].ed1);
         chk($sformatf("tbl%0d_d2", i), d2, tbl[i].ed2);
         chk($sformatf("tbl%0d_oc1", i), W'(oc1), W'(tbl[i].eo1));
         chk($sformatf("tbl%0d_pend", i), W'(pend), W'(tbl[i].ep));
         chk($sformatf("tbl%0d_erro", i), W'(erro), W'(tbl[i].ee));
         chk_model();
         edge_step();
      end

      drive(1'b1, 5'd7, 32'hA5A5A5A5, 1'b0, 5'd0, 5'd7, 5'd0);
      #1;
      chk("fwd_d1_byp", d1, 32'hA5A5A5A5);
      chk("fwd_oc1_byp", W'(oc1), '0);
      chk("fwd_d1_nobyp_old", d1_0, '0);
      edge_step();
      drive(1'b0, 5'd0, '0, 1'b0, 5'd0, 5'd7, 5'd0);
      #1;
      chk("fwd_d1_nobyp_new", d1_0, 32'hA5A5A5A5);
      chk_model();

      for (int r = 1; r <= 3; r++) begin
         drive(1'b0, 5'd0, '0, 1'b1, A'(r), 5'd8, 5'd3);
         edge_step();
      end
      drive(1'b1, 5'd8, 32'h55, 1'b0, 5'd0, 5'd8, 5'd3);
      edge_step();
      drive(1'b0, 5'd0, '0, 1'b0, 5'd0, 5'd8, 5'd3);
      #1;
      chk("pre_rst_d1", d1, 32'h55);
      chk("pre_rst_pend", W'(pend), 32'd4);
      chk("pre_rst_oc2", W'(oc2), 32'd1);
      rst_n = 1'b0;
      mreset();
      #1;
      chk("async_rst_d1", d1, '0);
      chk("async_rst_d2", d2, '0);
      chk("async_rst_oc2", W'(oc2), '0);
      chk("async_rst_pend", W'(pend), '0);
      chk("async_rst_erro", W'(erro), '0);
      chk_model();
      #1 rst_n = 1'b1;
      #1;
      chk("post_rst_pend", W'(pend), '0);
      chk("post_rst_d1", d1, '0);
      @(negedge clk);

      for (int c = 0; c < 400; c++) begin
         drive(1'($urandom), A'($urandom_range(0, 7)), $urandom, 1'($urandom),
               A'($urandom_range(0, 7)), A'($urandom_range(0, 7)), A'($urandom_range(0, 7)));
         #1;
         chk_model();
         if (c == 200) begin
            rst_n = 1'b0;
            mreset();
            #1;
            chk_model();
            #1 rst_n = 1'b1;
         end
         edge_step();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
